matrix_result_writer: RTL

Drains a computed 5x5 inverse matrix into a 32-bit word-addressed result RAM. It is the write-side counterpart of the ROM-fed matrix load path: the inverse engine presents all 25 words in parallel with a `start` pulse. This block captures them, then writes them row-major through a stallable write port, followed by a checksum word. It signals completion, or skips all writes when the engine flags a singular matrix.

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_result_writer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the 5x5 matrix load/store paths.
// Holds the matrix geometry, the result-writer state encoding and a flat-bus word extractor.
// No logic here; the constants and the enum are consumed by the writer and its neighbours.
package matrix_pkg;

  localparam int N           = 5;
  localparam int DATA_W      = 32;
  localparam int NWORDS      = N * N;
  localparam int CSUM_OFFSET = NWORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CSUM  = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  // Word k of a row-major flattened matrix; element (1,1) sits in the low bits.
  function automatic logic [DATA_W-1:0] flat_word(input logic [NWORDS*DATA_W-1:0] flat,
                                                   input int unsigned k);
    return flat[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/matrix_result_writer.sv
// Captures a 5x5 inverse on start and writes it row-major plus a checksum word to the result RAM.
// Latency: first word one cycle after start, done 27 cycles after start with no stalls; singular done in 1.
// Backpressure: wr_ready low holds wr_addr/wr_data stable and adds one cycle per stalled cycle.
module matrix_result_writer #(
  parameter int DATA_W    = 32,
  parameter int N         = 5,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  singular,
  input  logic [N*N*DATA_W-1:0] mat_flat,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  import matrix_pkg::*;

  localparam int NW       = N * N;
  localparam int IDX_W    = $clog2(NW);
  localparam int CSUM_OFF = NW;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] CSUM_ADDR = ADDR_W'(BASE_ADDR + CSUM_OFF);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NW - 1);

  wr_state_t         state_q, state_d;
  logic [DATA_W-1:0] buf_q [NW];
  logic              cap_en;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [DATA_W-1:0] csum_q, csum_d, csum_add;
  logic              sing_q, sing_d;

  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              busy_d, done_d, error_d;
  logic              xfer;

  assign xfer     = wr_en && wr_ready;
  assign idx_inc  = idx_q + 1'b1;
  assign csum_add = csum_q + buf_q[idx_q];

  // Next state, datapath and next registered outputs; the write port presents the next word one edge ahead.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    sing_d    = sing_q;
    cap_en    = 1'b0;
    wr_en_d   = wr_en;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_en = 1'b1;
          idx_d  = '0;
          csum_d = '0;
          sing_d = singular;
          if (singular) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = BASE;
            wr_data_d = flat_word(mat_flat, 0);
          end
        end
      end

      WRITE: begin
        if (xfer) begin
          csum_d = csum_add;
          if (idx_q == LAST_IDX) begin
            state_d   = CSUM;
            wr_addr_d = CSUM_ADDR;
            wr_data_d = csum_add;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = BASE + ADDR_W'(idx_inc);
            wr_data_d = buf_q[idx_inc];
          end
        end
      end

      CSUM: begin
        if (xfer) begin
          state_d   = DONE;
          wr_en_d   = 1'b0;
          wr_addr_d = '0;
          wr_data_d = '0;
          done_d    = 1'b1;
          error_d   = sing_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, index, accumulator and all outputs are registered; reset abandons any write in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      sing_q  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      sing_q  <= sing_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

  // Capture buffer; only loaded by an accepted start, so contents need no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int k = 0; k < NW; k++) begin
        buf_q[k] <= flat_word(mat_flat, k);
      end
    end
  end

endmodule
